// File: rtl/fetch_redirect_align.sv
// Fetch PC generator with fixed-priority redirect arbitration and misaligned-target trap.
// FETCH_ALIGN_RVC_EN relaxes target alignment from 4 to 2 bytes (compressed ISA).
module fetch_redirect_align #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    NUM_SRC     = 3,
    parameter int                    FETCH_BYTES = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
    localparam int                   SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_SRC-1:0]            redir_valid_i,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] redir_addr_i,
    input  logic                          fetch_ready_i,
    output logic                          fetch_valid_o,
    output logic [ADDR_WIDTH-1:0]         fetch_pc_o,
    output logic                          exc_valid_o,
    output logic [ADDR_WIDTH-1:0]         exc_addr_o,
    output logic [SRC_W-1:0]              exc_src_o,
    input  logic                          exc_ack_i,
    input  logic [ADDR_WIDTH-1:0]         trap_vec_i
);

`ifdef FETCH_ALIGN_RVC_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(1);
`else
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(3);
`endif

    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(FETCH_BYTES);

    if ((RESET_PC & ALIGN_MASK) != '0) begin : g_bad_reset_pc
        $error("RESET_PC is not aligned to the fetch granule");
    end
    if (FETCH_BYTES < 4 || (FETCH_BYTES & (FETCH_BYTES - 1)) != 0) begin : g_bad_fetch_bytes
        $error("FETCH_BYTES must be a power of two, at least 4");
    end

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        EXC_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  win_hit;
    logic [SRC_W-1:0]      win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_misaligned;

    // Scan from the lowest priority upward so the lowest index is written last.
    always_comb begin
        win_hit  = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                win_hit  = 1'b1;
                win_idx  = SRC_W'(k);
                win_addr = redir_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign win_misaligned = (win_addr & ALIGN_MASK) != '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:     state_d = RUN;
            RUN:      if (win_hit && win_misaligned) state_d = EXC_WAIT;
            EXC_WAIT: if (exc_ack_i) state_d = RUN;
            default:  state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid_o = (state_q == RUN);
        exc_valid_o   = (state_q == EXC_WAIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_o <= RESET_PC;
            exc_addr_o <= '0;
            exc_src_o  <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (win_hit) begin
                        if (win_misaligned) begin
                            exc_addr_o <= win_addr;
                            exc_src_o  <= win_idx;
                        end else begin
                            fetch_pc_o <= win_addr;
                        end
                    end else if (fetch_ready_i) begin
                        fetch_pc_o <= fetch_pc_o + INC;
                    end
                end
                EXC_WAIT: begin
                    if (exc_ack_i) begin
                        fetch_pc_o <= trap_vec_i & ~ALIGN_MASK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fetch_redirect_align.md
Name: fetch_redirect_align

Overview:
- Parametrised fetch-address generator with an instruction-alignment checker for the IFU front end.
- Arbitrates NUM_SRC redirect sources by fixed priority and owns the architectural fetch PC register.
- Detects misaligned redirect targets, raises a registered exception that is held until the trap unit acknowledges it, stalls fetch meanwhile, then restarts fetch at the trap vector.

Parameters:
- ADDR_WIDTH, 64, width of all addresses.
- NUM_SRC, 3, number of redirect sources; index 0 is highest priority (0 = BRU mispredict, 1 = BPU taken, 2 = spare/CSR).
- FETCH_BYTES, 4, sequential PC increment per accepted fetch; power of two, at least 4.
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- redir_valid_i  in  NUM_SRC  per-source redirect request.
- redir_addr_i  in  NUM_SRC*ADDR_WIDTH  packed targets; source k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- fetch_ready_i  in  1  downstream accepts the current fetch PC.
- fetch_valid_o  out  1  fetch_pc_o is valid.
- fetch_pc_o  out  ADDR_WIDTH  current fetch PC.
- exc_valid_o  out  1  misaligned-fetch exception pending.
- exc_addr_o  out  ADDR_WIDTH  offending target address.
- exc_src_o  out  $clog2(NUM_SRC) (minimum 1)  index of the source that caused the exception.
- exc_ack_i  in  1  trap unit has taken the exception.
- trap_vec_i  in  ADDR_WIDTH  trap handler address, sampled on ack.

Behaviour:
- Reset values (async): state=BOOT, fetch_pc_o=RESET_PC, fetch_valid_o=0, exc_valid_o=0, exc_addr_o=0, exc_src_o=0.
- Alignment granule G = 4 bytes. An address is misaligned if addr[1:0] != 0.
- Priority select: lowest index k with redir_valid_i[k]=1 wins; all other sources are ignored that cycle.
- State BOOT:
  - Lasts exactly one cycle after reset deassert, then moves to RUN.
  - fetch_valid_o=0; redirects are ignored.
- State RUN (fetch_valid_o=1):
  - Winner aligned: fetch_pc_o <= winner addr on the next edge. A redirect overrides any increment, regardless of fetch_ready_i.
  - Winner misaligned:
    - Next state EXC_WAIT.
    - exc_valid_o <= 1, exc_addr_o <= winner addr, exc_src_o <= k.
    - fetch_valid_o <= 0; fetch_pc_o is unchanged.
  - No redirect and fetch_ready_i=1: fetch_pc_o <= fetch_pc_o + FETCH_BYTES, wrapping modulo 2^ADDR_WIDTH.
  - No redirect and fetch_ready_i=0: hold.
- State EXC_WAIT (fetch_valid_o=0, exc_valid_o=1):
  - exc_addr_o and exc_src_o are stable; all redirects are ignored.
  - On exc_ack_i=1:
    - exc_valid_o <= 0; fetch_pc_o <= trap_vec_i with bits [1:0] forced to 0.
    - Next state RUN; fetch_valid_o <= 1.
- exc_ack_i outside EXC_WAIT is ignored.
- Latency:
  - Redirect to new fetch_pc_o: 1 cycle.
  - Misaligned redirect to exc_valid_o: 1 cycle.
  - Ack to fetch restart: 1 cycle.
- A misaligned lower-priority source is masked when a higher-priority source is valid; no exception is raised for it.
- The sequential increment never creates misalignment, because RESET_PC and all accepted targets are aligned. RESET_PC must be aligned; misalignment is a parameter error, caught by an elaboration-time check.
- Reset asserted mid-EXC_WAIT or mid-RUN returns immediately to the reset values.

Optional Feature:
- Macro FETCH_ALIGN_RVC_EN.
- Defined (C extension):
  - G = 2; misaligned only if addr[0] != 0.
  - The sequential increment is still FETCH_BYTES.
  - The trap vector has only bit 0 forced to 0.
- Undefined: G = 4 as described above; RVC-aligned targets (addr[1:0]=2'b10) raise the exception.

Test Plan:
- Reset release with fetch_ready_i=1 held → BOOT 1 cycle, then fetch_pc_o = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, fetch_valid_o=1.
- In RUN: redir_valid_i=3'b011, src0=0x1000, src1=0x2000 → next cycle fetch_pc_o=0x1000; src1 ignored.
- In RUN: redir_valid_i=3'b010, src1=0x2002 → next cycle exc_valid_o=1, exc_addr_o=0x2002, exc_src_o=1, fetch_valid_o=0.
  - With FETCH_ALIGN_RVC_EN defined → instead fetch_pc_o=0x2002, no exception.
- In EXC_WAIT: hold exc_ack_i=0 for 5 cycles with redirect src0=0x3000 valid → exc outputs stable, fetch_pc_o unchanged. Then exc_ack_i=1, trap_vec_i=0x8000_0103 → next cycle exc_valid_o=0, fetch_pc_o=0x8000_0100, fetch_valid_o=1.
- fetch_pc_o=0xFFFF_FFFF_FFFF_FFFC, fetch_ready_i=1, no redirect → next fetch_pc_o=0x0 (wrap).
- Assert rst_i asynchronously mid-EXC_WAIT → outputs return to reset values before the next clock edge.
